// File: rtl/elbeth_definitions.sv
// elbeth_definitions: shared state encoding, CSR addresses and exception codes for the trap sequencer
package elbeth_definitions;
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_DRAIN      = 3'd1;
  localparam logic [2:0] ST_SAVE_EPC   = 3'd2;
  localparam logic [2:0] ST_SAVE_CAUSE = 3'd3;
  localparam logic [2:0] ST_TRAP_JUMP  = 3'd4;
  localparam logic [2:0] ST_ERET_JUMP  = 3'd5;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [3:0] ECODE_ILLEGAL = 4'h2;
  localparam logic [3:0] ECODE_EBREAK  = 4'h3;
  localparam logic [3:0] ECODE_ECALL_M = 4'hb;
  typedef enum logic {KIND_TRAP = 1'b0, KIND_ERET = 1'b1} trap_kind_e;
endpackage

// File: rtl/elbeth_trap_sequencer.sv
// elbeth_trap_sequencer: drains EX, saves mepc/mcause and redirects the PC on traps and ERET
module elbeth_trap_sequencer
  import elbeth_definitions::*;
#(
  parameter int          DRAIN_LIMIT   = 16,
  parameter logic [31:0] MTVEC_DEFAULT = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_except_valid,
  input  logic [3:0]  id_except_src,
  input  logic        id_eret,
  input  logic [31:0] id_pc,
  input  logic        ex_busy,
  input  logic [31:0] csr_mtvec,
  input  logic        csr_mtvec_valid,
  input  logic [31:0] csr_mepc,
  output logic        csr_wr_en,
  output logic [11:0] csr_wr_addr,
  output logic [31:0] csr_wr_data,
  output logic        pipe_stall,
  output logic        pipe_flush,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        prv_push,
  output logic        prv_pop,
  output logic        trap_busy,
  output logic        drain_timeout
);
  localparam int CW = DRAIN_LIMIT > 1 ? $clog2(DRAIN_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DRAIN_LIMIT - 1);
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_pc;
  logic [3:0]    r_cause;
  trap_kind_e    r_kind;
  logic          w_cnt_max;
  assign w_cnt_max = r_cnt == CNT_MAX;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_cause <= '0;
      r_kind  <= KIND_TRAP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (id_except_valid) begin
            r_pc    <= id_pc;
            r_cause <= id_except_src;
            r_kind  <= KIND_TRAP;
            r_state <= ST_DRAIN;
          end else if (id_eret) begin
            r_kind  <= KIND_ERET;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The counter saturates at the limit, where the timeout forces the exit anyway
          if (ex_busy && !w_cnt_max) r_cnt <= r_cnt + 1'b1;
          if (!ex_busy || w_cnt_max) r_state <= r_kind == KIND_TRAP ? ST_SAVE_EPC : ST_ERET_JUMP;
        end
        ST_SAVE_EPC:   r_state <= ST_SAVE_CAUSE;
        ST_SAVE_CAUSE: r_state <= ST_TRAP_JUMP;
        default:       r_state <= ST_IDLE;
      endcase
    end
  end
  always_comb begin
    trap_busy     = r_state != ST_IDLE;
    pipe_stall    = r_state != ST_IDLE;
    csr_wr_en     = r_state == ST_SAVE_EPC || r_state == ST_SAVE_CAUSE;
    csr_wr_addr   = r_state == ST_SAVE_EPC ? CSR_MEPC : r_state == ST_SAVE_CAUSE ? CSR_MCAUSE : 12'h0;
    csr_wr_data   = r_state == ST_SAVE_EPC ? r_pc : r_state == ST_SAVE_CAUSE ? {28'b0, r_cause} : 32'h0;
    pc_redirect   = r_state == ST_TRAP_JUMP || r_state == ST_ERET_JUMP;
    pipe_flush    = r_state == ST_TRAP_JUMP || r_state == ST_ERET_JUMP;
    prv_push      = r_state == ST_TRAP_JUMP;
    prv_pop       = r_state == ST_ERET_JUMP;
    pc_target     = r_state == ST_TRAP_JUMP ? (csr_mtvec_valid ? csr_mtvec : MTVEC_DEFAULT) :
                    r_state == ST_ERET_JUMP ? csr_mepc : 32'h0;
    drain_timeout = r_state == ST_DRAIN && w_cnt_max;
  end
endmodule

// File: doc/elbeth_trap_sequencer.md
ELBETH_TRAP_SEQUENCER -- requirements
Module: elbeth_trap_sequencer

Interface
REQ-001 SHALL have parameter DRAIN_LIMIT, default 16: maximum cycles spent waiting for EX to drain before the sequence proceeds anyway.
REQ-002 SHALL have parameter MTVEC_DEFAULT, default 32'h0000_0100: trap target used when csr_mtvec_valid is low.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port id_except_valid  in  1  the ID stage flags an exception (illegal instruction, ecall or ebreak).
REQ-006 SHALL have port id_except_src  in  4  exception cause code from the decoder.
REQ-007 SHALL have port id_eret  in  1  the ID stage holds a legal ERET.
REQ-008 SHALL have port id_pc  in  32  PC of the instruction in ID.
REQ-009 SHALL have port ex_busy  in  1  a multi-cycle operation is still active in EX.
REQ-010 SHALL have ports csr_mtvec  in  32, csr_mtvec_valid  in  1 and csr_mepc  in  32: CSR read values.
REQ-011 SHALL have ports csr_wr_en  out  1, csr_wr_addr  out  12 and csr_wr_data  out  32: single-cycle CSR write port.
REQ-012 SHALL have ports pipe_stall  out  1 (freeze IF/ID) and pipe_flush  out  1 (squash IF/ID/EX).
REQ-013 SHALL have ports pc_redirect  out  1 and pc_target  out  32: one-cycle PC load.
REQ-014 SHALL have ports prv_push  out  1 (enter machine mode) and prv_pop  out  1 (restore privilege).
REQ-015 SHALL have ports trap_busy  out  1 (state not IDLE) and drain_timeout  out  1 (one-cycle pulse).

Function
REQ-016 SHALL implement the states IDLE, DRAIN, SAVE_EPC, SAVE_CAUSE, TRAP_JUMP and ERET_JUMP.
REQ-017 IDLE: on id_except_valid, SHALL latch id_pc and id_except_src and go to DRAIN with kind=TRAP; otherwise on id_eret, go to DRAIN with kind=ERET.
REQ-018 SHALL give exceptions priority over ERET when both are asserted in the same cycle.
REQ-019 SHALL ignore requests in any state other than IDLE.
REQ-020 DRAIN SHALL last at least 1 cycle, clear the drain counter on entry, and increment it each cycle that ex_busy is high.
REQ-021 DRAIN SHALL exit when ex_busy is low, or when the counter equals DRAIN_LIMIT-1 (pulse drain_timeout in that cycle); it goes to SAVE_EPC for kind=TRAP or ERET_JUMP for kind=ERET.
REQ-022 SAVE_EPC SHALL drive csr_wr_en=1, csr_wr_addr=12'h341, csr_wr_data=the latched pc.
REQ-023 SAVE_CAUSE SHALL drive csr_wr_en=1, csr_wr_addr=12'h342, csr_wr_data={28'b0, latched cause}.
REQ-024 TRAP_JUMP SHALL drive pc_redirect=1, pipe_flush=1, prv_push=1 and pc_target=csr_mtvec (MTVEC_DEFAULT when csr_mtvec_valid is low), then return to IDLE.
REQ-025 ERET_JUMP SHALL drive pc_redirect=1, pipe_flush=1, prv_pop=1 and pc_target=csr_mepc sampled in that cycle, then return to IDLE.
REQ-026 pipe_stall and trap_busy SHALL be 1 in every state except IDLE; all outputs are Moore (decoded from registered state only).
REQ-027 Trap latency SHALL be exactly 4 cycles from the accept edge to the pc_redirect cycle when ex_busy is low; ERET latency SHALL be 2 cycles.
REQ-028 When not asserted, csr_wr_en, pc_redirect, pipe_flush, prv_push, prv_pop and drain_timeout SHALL be 0, with csr_wr_addr/data=0 and pc_target=0.
REQ-029 The drain counter SHALL be $clog2(DRAIN_LIMIT) bits wide, saturate at DRAIN_LIMIT-1, and never wrap.
REQ-030 A request present in the cycle after TRAP_JUMP or ERET_JUMP (back in IDLE) SHALL be accepted normally, allowing back-to-back sequences.

Reset
REQ-031 With rst=1 at a clock edge, SHALL set state=IDLE, clear the counter, latched pc/cause and kind, and hold every output at 0 from the following cycle.
REQ-032 Reset asserted mid-sequence SHALL abort it with no further CSR write or redirect.

Structure
REQ-033 State encoding, CSR addresses (MEPC 12'h341, MCAUSE 12'h342) and ECODE values SHALL live in elbeth_definitions; no sub-module is required.

Verification
REQ-034 Illegal instruction at pc 0x40, src 4'h2, ex_busy=0, mtvec 0x100 -> mepc write 0x40, then mcause write 0x2, then redirect to 0x100 with flush and prv_push 4 cycles after accept.
REQ-035 Exception while ex_busy is high for 3 cycles -> DRAIN holds 3 cycles with stall=1, the sequence then completes with no drain_timeout.
REQ-036 ex_busy stuck at 1 -> drain_timeout pulses after 16 DRAIN cycles, then the sequence proceeds.
REQ-037 id_eret with mepc 0x80 -> redirect to 0x80, prv_pop, no CSR writes, 2 cycles after accept.
REQ-038 id_except_valid and id_eret in the same cycle -> trap path taken; a second exception during SAVE_CAUSE is ignored.
REQ-039 rst pulsed in SAVE_EPC -> no SAVE_CAUSE write and no redirect; state is IDLE and outputs are 0.
